// File: rtl/ksa28_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ksa28_share_ctrl_if
// Brief    : Requester, shared-adder and response signals of the KSA28 share
//            controller, with controller (slave) and environment (master) views.
// Revision : 1.0 - initial release
// ============================================================================
interface ksa28_share_ctrl_if #(
    parameter int WIDTH = 28
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_tag;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  add_sum, add_cout, rsp_ready,
        output req0_ready, req1_ready,
        output add_a, add_b, add_cin,
        output rsp_valid, rsp_tag, rsp_sum, rsp_cout, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output add_sum, add_cout, rsp_ready,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_cin,
        input  rsp_valid, rsp_tag, rsp_sum, rsp_cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/ksa28_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ksa28_share_ctrl
// Brief    : Round-robin two-requester scheduler feeding one shared 28-bit
//            adder through an issue stage and a tagged result stage.
// Revision : 1.0 - initial release
// ============================================================================
module ksa28_share_ctrl #(
    parameter int WIDTH = 28
) (
    input  logic              clk,
    input  logic              rst,
    ksa28_share_ctrl_if.slave bus
);
    logic             s1_valid_q, s1_valid_d;
    logic             s1_tag_q,   s1_tag_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_cin_q,   s1_cin_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_tag_q,   rsp_tag_d;
    logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
    logic             rsp_cout_q,  rsp_cout_d;

    logic             rr_q, rr_d;

    logic w_s2_free, w_s1_adv, w_s1_open;
    logic w_grant0, w_grant1, w_ready0, w_ready1;

    always_comb begin
        w_s2_free = !rsp_valid_q || bus.rsp_ready;
        w_s1_adv  = w_s2_free;
        w_s1_open = !s1_valid_q || w_s1_adv;
        // A lone requester wins outright; a contest is settled by rr.
        w_grant0  = bus.req0_valid && (!bus.req1_valid || !rr_q);
        w_grant1  = bus.req1_valid && (!bus.req0_valid ||  rr_q);
        w_ready0  = !rst && w_s1_open && w_grant0;
        w_ready1  = !rst && w_s1_open && w_grant1;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rr_d        = rr_q;

        if (w_ready0 || w_ready1) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = w_ready1;
            s1_a_d     = w_ready1 ? bus.req1_a   : bus.req0_a;
            s1_b_d     = w_ready1 ? bus.req1_b   : bus.req0_b;
            s1_cin_d   = w_ready1 ? bus.req1_cin : bus.req0_cin;
            rr_d       = w_ready0;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // The adder sees only the issue registers, so S2 captures a full-cycle path.
        if (w_s1_adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_tag_d   = s1_tag_q;
            rsp_sum_d   = bus.add_sum;
            rsp_cout_d  = bus.add_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.add_a      = s1_a_q;
    assign bus.add_b      = s1_b_q;
    assign bus.add_cin    = s1_cin_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.busy       = s1_valid_q || rsp_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_ksa28_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ksa28_share_ctrl
// Brief    : Directed bench for ksa28_share_ctrl with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ksa28_share_ctrl;
    localparam int WIDTH = 28;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ksa28_share_ctrl_if #(.WIDTH(WIDTH)) bus ();
    ksa28_share_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Stand-in for the shared Kogge-Stone adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                         + {{WIDTH{1'b0}}, bus.add_cin};

    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;
    logic [31:0] sb[$];
    logic        glog[$];
    bit          auto_refresh = 1'b0;

    logic             s_rdy0, s_rdy1, s_rsp_valid, s_tag, s_cout, s_busy, s_add_cin;
    logic [WIDTH-1:0] s_sum, s_add_a, s_add_b, held_sum;
    logic             hs0, hs1;
    int               base;
    logic             exp3[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic             exp4[3] = '{1'b0, 1'b1, 1'b0};
    logic             exp6[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic tag, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        return {2'b00, tag, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [31:0] r;
        r = $urandom();
        return r[WIDTH-1:0];
    endfunction

    // One clock: sample at negedge, score, then step past the rising edge.
    task automatic cycle();
        logic [31:0] exp;
        @(negedge clk);
        s_rdy0      = bus.req0_ready;
        s_rdy1      = bus.req1_ready;
        s_rsp_valid = bus.rsp_valid;
        s_tag       = bus.rsp_tag;
        s_sum       = bus.rsp_sum;
        s_cout      = bus.rsp_cout;
        s_busy      = bus.busy;
        s_add_a     = bus.add_a;
        s_add_b     = bus.add_b;
        s_add_cin   = bus.add_cin;
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_cnt++;
            chk("sb_expected_rsp", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("sb_rsp", {2'b00, bus.rsp_tag, bus.rsp_cout, bus.rsp_sum}, exp);
            end
        end
        if (hs0) begin
            sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin));
            glog.push_back(1'b0);
        end
        if (hs1) begin
            sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin));
            glog.push_back(1'b1);
        end
        @(posedge clk);
        #1;
        if (auto_refresh && hs0) begin
            bus.req0_a = rnd(); bus.req0_b = rnd(); bus.req0_cin = rnd() > 28'h8000000;
        end
        if (auto_refresh && hs1) begin
            bus.req1_a = rnd(); bus.req1_b = rnd(); bus.req1_cin = rnd() > 28'h8000000;
        end
    endtask

    task automatic drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !bus.busy) break;
            cycle();
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready  = 1'b1;

        // Reset state; a pending request must not be accepted while in reset
        cycle();
        cycle();
        chk("rst_ready0", 32'(s_rdy0), 32'd0);
        chk("rst_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_add_a", 32'(s_add_a), 32'd0);
        chk("rst_add_b", 32'(s_add_b), 32'd0);
        chk("rst_add_cin", 32'(s_add_cin), 32'd0);
        chk("rst_rsp_sum", 32'(s_sum), 32'd0);
        chk("rst_rsp_cout", 32'(s_cout), 32'd0);
        chk("rst_rsp_tag", 32'(s_tag), 32'd0);

        // Test 1: requester 0 alone, two-cycle latency
        rst = 1'b0;
        bus.req0_a = 28'h0FFFFFF; bus.req0_b = 28'h0000001; bus.req0_cin = 1'b0;
        cycle();
        chk("t1_ready0", 32'(s_rdy0), 32'd1);
        bus.req0_valid = 1'b0;
        cycle();
        chk("t1_not_yet", 32'(s_rsp_valid), 32'd0);
        chk("t1_add_a", 32'(s_add_a), 32'h0FFFFFF);
        cycle();
        chk("t1_rsp_valid", 32'(s_rsp_valid), 32'd1);
        chk("t1_tag", 32'(s_tag), 32'd0);
        chk("t1_sum", 32'(s_sum), 32'h1000000);
        chk("t1_cout", 32'(s_cout), 32'd0);

        // Test 2: carry-out wrap on requester 1
        bus.req1_valid = 1'b1;
        bus.req1_a = 28'hFFFFFFF; bus.req1_b = 28'h0000001; bus.req1_cin = 1'b1;
        cycle();
        chk("t2_ready1", 32'(s_rdy1), 32'd1);
        bus.req1_valid = 1'b0;
        cycle();
        cycle();
        chk("t2_rsp_valid", 32'(s_rsp_valid), 32'd1);
        chk("t2_sum", 32'(s_sum), 32'h0000001);
        chk("t2_cout", 32'(s_cout), 32'd1);
        chk("t2_tag", 32'(s_tag), 32'd1);
        drain();

        // Test 3: both requesters continuously valid, full throughput
        glog.delete();
        base = rsp_cnt;
        auto_refresh = 1'b1;
        bus.req0_a = rnd(); bus.req0_b = rnd(); bus.req0_cin = 1'b1;
        bus.req1_a = rnd(); bus.req1_b = rnd(); bus.req1_cin = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_one_grant", 32'(hs0) + 32'(hs1), 32'd1);
            if (i >= 2) chk("t3_rsp_each_cycle", 32'(s_rsp_valid), 32'd1);
        end
        chk("t3_rsp_in_window", 32'(rsp_cnt - base), 32'd4);
        drain();
        chk("t3_rsp_total", 32'(rsp_cnt - base), 32'd6);
        chk("t3_glog_len", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t3_grant_order", 32'(glog[i]), 32'(exp3[i]));

        // Test 4: back-pressure with both requesters valid
        glog.delete();
        base = rsp_cnt;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        cycle();
        chk("t4_hs_c1", 32'(hs0) + 32'(hs1), 32'd1);
        cycle();
        chk("t4_hs_c2", 32'(hs0) + 32'(hs1), 32'd1);
        cycle();
        chk("t4_ready0_stall", 32'(s_rdy0), 32'd0);
        chk("t4_ready1_stall", 32'(s_rdy1), 32'd0);
        chk("t4_rsp_valid_stall", 32'(s_rsp_valid), 32'd1);
        held_sum = s_sum;
        cycle();
        chk("t4_ready0_stall2", 32'(s_rdy0), 32'd0);
        chk("t4_ready1_stall2", 32'(s_rdy1), 32'd0);
        chk("t4_sum_held", 32'(s_sum), 32'(held_sum));
        bus.rsp_ready = 1'b1;
        cycle();
        chk("t4_release_grant0", 32'(hs0), 32'd1);
        drain();
        chk("t4_rsp_total", 32'(rsp_cnt - base), 32'd3);
        chk("t4_glog_len", 32'(glog.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("t4_grant_order", 32'(glog[i]), 32'(exp4[i]));

        // Test 5: reset with both stages full, rr left pointing at requester 1
        auto_refresh  = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1;
        cycle();
        chk("t5_fill1", 32'(hs1), 32'd1);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        cycle();
        chk("t5_fill0", 32'(hs0), 32'd1);
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        cycle();
        sb.delete();
        glog.delete();
        rst = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        cycle();
        chk("t5_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("t5_busy", 32'(s_busy), 32'd0);
        chk("t5_add_a", 32'(s_add_a), 32'd0);
        chk("t5_add_b", 32'(s_add_b), 32'd0);
        chk("t5_first_grant0", 32'(hs0), 32'd1);
        chk("t5_no_grant1", 32'(hs1), 32'd0);
        drain();

        // Test 6: requester 0 alone after rr was steered to 0 by requester 1
        glog.delete();
        auto_refresh = 1'b1;
        bus.req1_valid = 1'b1;
        cycle();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_ready0_no_bubble", 32'(s_rdy0), 32'd1);
        end
        bus.req1_valid = 1'b1;
        cycle();
        chk("t6_contest_to_1", 32'(hs1), 32'd1);
        drain();
        chk("t6_glog_len", 32'(glog.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk("t6_grant_order", 32'(glog[i]), 32'(exp6[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ksa28_share_ctrl.md
# ksa28_share_ctrl

Two-requester scheduler that time-shares one 28-bit Kogge-Stone adder in the floating-point datapath. Round-robin arbitration picks one requester per cycle. Its operands are registered into an issue stage that drives the shared adder. The adder result is captured into a tagged output stage. A valid/ready handshake with back-pressure sequences the whole path, so neither requester drives the adder directly.

## Interface

Parameters:
- WIDTH, 28, operand/sum width; must match the adder instance.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- add_a, add_b  output  WIDTH  to adder A/B, straight from issue registers.
- add_cin  output  1  to adder carry-in, from issue register.
- add_sum  input  WIDTH  combinational adder sum.
- add_cout  input  1  combinational adder carry-out.
- rsp_valid  output  1  result stage holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_tag  output  1  requester that owns the result (0/1).
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry-out.
- busy  output  1  issue or result stage occupied.

## Operation

Stages:
- S1 (issue): s1_valid, s1_tag, and the a/b/cin registers. These registers drive add_* continuously.
- S2 (result): rsp_valid, rsp_tag, rsp_sum, rsp_cout.

Stall and advance:
- s2_free = !rsp_valid || rsp_ready.
- s1_adv = s2_free. When it is set, S2 loads S1: valid, tag, add_sum, add_cout.
- s1_open = !s1_valid || s1_adv. When it is set, S1 may accept a grant.

Arbitration (round-robin pointer rr, 1 bit):
- Both valid: grant the requester selected by rr.
- One valid: grant that requester.
- A grant happens only when s1_open = 1.
- reqX_ready = s1_open && grantX. The two readies are never high together.
- A grant that completes a handshake sets rr = !granted_id.
- rr is unchanged when there is no handshake, including during a stall.

Other rules:
- If no grant occurs but s1_adv = 1, s1_valid clears.
- The adder output is sampled only from S1 contents, never from requester inputs. No combinational path runs from req*_a/b to the adder.
- Arithmetic: sum and cout are passed through unmodified. Width is WIDTH; there is no truncation or extension.
- Requesters hold valid and operands stable until ready. The controller does not check this.
- busy = s1_valid || rsp_valid.

Reset values (rst = 1 at a clock edge):
- s1_valid = 0, rsp_valid = 0, rr = 0 (requester 0 first).
- s1/rsp data and tags = 0, so add_a = add_b = 0, add_cin = 0, rsp_sum = 0, rsp_cout = 0, rsp_tag = 0.
- busy = 0.
- A mid-operation reset discards both in-flight operations. No response is produced for them.
- req*_ready = 0 while rst is asserted.

## Timing

- Handshake at edge N:
  - operands in S1 after edge N;
  - result in S2 and rsp_valid = 1 after edge N+1.
  - Latency is 2 cycles, with the full cycle between them available to the adder.
- Throughput is 1 operation/cycle while rsp_ready = 1.
- Back-pressure, with rsp_ready = 0 and rsp_valid = 1:
  - S2 holds.
  - S1 holds if valid; otherwise one new operation may enter S1.
  - req*_ready then drops.
  - Capacity is 2 in-flight operations.
- rsp_ready rising releases both stages on the same edge. A new grant may enter S1 on that edge.
- Results leave in acceptance order. The tag identifies the owner.

## Test plan

- Reset, then requester 0 only: a=0x0FFFFFF, b=0x0000001, cin=0. Required: handshake at cycle 1; at cycle 3, rsp_valid=1, tag=0, sum=0x1000000, cout=0.
- Carry-out wrap: a=0xFFFFFFF, b=0x0000001, cin=1 on requester 1. Required: sum=0x0000001, cout=1, tag=1.
- Both requesters valid continuously for 6 cycles, rsp_ready=1. Required: grants 0,1,0,1,0,1; one result per cycle after a 2-cycle latency; tags in the same order.
- Back-pressure: rsp_ready=0 for 4 cycles while both requesters are valid. Required: exactly 2 handshakes, then req*_ready=0; rsp_sum held stable; rr unchanged during the stall. On release, the results drain in order with no loss and no duplicate.
- Reset asserted with both stages full. Required: rsp_valid=0, busy=0, add_a=add_b=0 next cycle; the first post-reset contested grant goes to requester 0.
- Single requester after a grant to 0: requester 1 is idle and requester 0 issues again. Required: requester 0 is granted each cycle; rr toggles to 1 after every handshake; there is no bubble.
